// File: rtl/seq_div_pkg.sv
// ---------------------------------------------------------------------------
// seq_div_pkg
// Shared types and helpers for the sequential restoring divider seq_div_tc.
//   state_t        : divider FSM states (IDLE, CALC, FIXUP, DONE)
//   MAX_W          : widest operand the magnitude/negate helpers handle
//   counter_width  : width of the bit counter for a given dividend width
//   negate         : two's complement negation on a MAX_W-bit value
//   magnitude      : conditional negation (absolute value of a signed operand)
// Callers zero-extend narrower operands to MAX_W and size-cast the result
// back down; negation modulo 2^MAX_W truncates correctly to any width.
// ---------------------------------------------------------------------------
package seq_div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIXUP,
        DONE
    } state_t;

    localparam int MAX_W = 64;

    function automatic int counter_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    function automatic logic [MAX_W-1:0] negate(input logic [MAX_W-1:0] value);
        return ~value + MAX_W'(1);
    endfunction

    function automatic logic [MAX_W-1:0] magnitude(input logic [MAX_W-1:0] value,
                                                   input logic              is_neg);
        return is_neg ? negate(value) : value;
    endfunction

endpackage

// File: rtl/seq_div_tc_if.sv
// ---------------------------------------------------------------------------
// seq_div_tc_if
// Request/result bundle of the sequential divider.
//   start, tc, a, b                         : request, driven by the master
//   complete, divide_by_0, quotient,
//   remainder                               : result, driven by the divider
// Modports: master (requester side), slave (divider side).
// ---------------------------------------------------------------------------
interface seq_div_tc_if #(
    parameter int a_width = 8,
    parameter int b_width = 8
);

    logic               start;
    logic               tc;
    logic [a_width-1:0] a;
    logic [b_width-1:0] b;
    logic               complete;
    logic               divide_by_0;
    logic [a_width-1:0] quotient;
    logic [b_width-1:0] remainder;

    modport master (
        output start, tc, a, b,
        input  complete, divide_by_0, quotient, remainder
    );

    modport slave (
        input  start, tc, a, b,
        output complete, divide_by_0, quotient, remainder
    );

endinterface

// File: rtl/seq_div_step.sv
// ---------------------------------------------------------------------------
// seq_div_step
// One combinational restoring-division step on unsigned magnitudes.
//   prem_in   in  b_width+1  partial remainder before the step
//   next_bit  in  1          next dividend bit (MSB first)
//   divisor   in  b_width    divisor magnitude
//   prem_out  out b_width+1  partial remainder after the step
//   q_bit     out 1          quotient bit retired by this step
// ---------------------------------------------------------------------------
module seq_div_step #(
    parameter int b_width = 8
) (
    input  logic [b_width:0]   prem_in,
    input  logic               next_bit,
    input  logic [b_width-1:0] divisor,
    output logic [b_width:0]   prem_out,
    output logic               q_bit
);

    logic [b_width+1:0] shifted;
    logic [b_width+1:0] divisor_ext;

    // Shift the next dividend bit into the partial remainder, then subtract
    // the divisor only if it fits. The compare runs one bit wider than the
    // register so the shifted value can never overflow; the restored result
    // is always below the divisor and fits back into b_width+1 bits.
    always_comb begin
        shifted     = {prem_in, next_bit};
        divisor_ext = {2'b00, divisor};
        q_bit       = (shifted >= divisor_ext);
        prem_out    = (b_width+1)'(q_bit ? (shifted - divisor_ext) : shifted);
    end

endmodule

// File: rtl/seq_div_tc.sv
// ---------------------------------------------------------------------------
// seq_div_tc
// Multi-cycle restoring divider, unsigned or two's complement (tc=1).
// One quotient bit is retired per clock; the result registers are written
// in FIXUP and complete rises one cycle later, a_width+2 edges after start
// is sampled.
//   clk        in  rising-edge clock
//   rst_n      in  asynchronous active-low reset
//   bus        slave modport of seq_div_tc_if:
//                start/tc/a/b in, complete/divide_by_0/quotient/remainder out
// Build option:
//   SEQDIV_REM_EN  defined   : remainder datapath and sign fixup are built
//                  undefined : remainder output is tied to 0
// Operand widths beyond seq_div_pkg::MAX_W are not supported.
// ---------------------------------------------------------------------------
module seq_div_tc
    import seq_div_pkg::*;
#(
    parameter int a_width = 8,
    parameter int b_width = 8
) (
    input logic         clk,
    input logic         rst_n,
    seq_div_tc_if.slave bus
);

    localparam int cnt_w = counter_width(a_width);

    state_t             state;
    state_t             state_next;
    logic               accept;

    logic [a_width-1:0] dvd;
    logic [b_width:0]   prem;
    logic [b_width:0]   prem_next;
    logic [b_width-1:0] b_mag;
    logic [cnt_w-1:0]   cnt;
    logic               q_bit;
    logic               q_neg;
    logic               a_neg;
    logic               tc_r;
    logic               div0_r;
    logic               a_sign;
    logic               b_sign;

    logic [a_width-1:0] q_fixed;
    logic [a_width-1:0] quotient_r;
    logic               div0_out;
    logic               complete_r;

`ifdef SEQDIV_REM_EN
    logic [a_width-1:0] a_r;
    logic [b_width-1:0] r_fixed;
    logic [b_width-1:0] remainder_r;
`endif

    assign a_sign = bus.tc & bus.a[a_width-1];
    assign b_sign = bus.tc & bus.b[b_width-1];

    seq_div_step #(
        .b_width (b_width)
    ) u_step (
        .prem_in  (prem),
        .next_bit (dvd[a_width-1]),
        .divisor  (b_mag),
        .prem_out (prem_next),
        .q_bit    (q_bit)
    );

    // State register. Reset drops any operation in flight back to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. A request is only taken in IDLE or DONE; start
    // while CALC or FIXUP is running is simply not looked at.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = CALC;
                end
            end
            CALC: begin
                if (cnt == '0) begin
                    state_next = FIXUP;
                end
            end
            FIXUP: begin
                state_next = DONE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand and iteration registers. On accept the operands are reduced
    // to magnitudes and the result signs are remembered; the dividend
    // register then doubles as the quotient shift register, taking one
    // quotient bit into its LSB for every dividend bit shifted out the top.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd    <= '0;
            prem   <= '0;
            b_mag  <= '0;
            cnt    <= '0;
            q_neg  <= 1'b0;
            a_neg  <= 1'b0;
            tc_r   <= 1'b0;
            div0_r <= 1'b0;
`ifdef SEQDIV_REM_EN
            a_r    <= '0;
`endif
        end else if (accept) begin
            dvd    <= a_width'(magnitude(MAX_W'(bus.a), a_sign));
            b_mag  <= b_width'(magnitude(MAX_W'(bus.b), b_sign));
            prem   <= '0;
            cnt    <= cnt_w'(a_width - 1);
            q_neg  <= a_sign ^ b_sign;
            a_neg  <= a_sign;
            tc_r   <= bus.tc;
            div0_r <= (bus.b == '0);
`ifdef SEQDIV_REM_EN
            a_r    <= bus.a;
`endif
        end else if (state == CALC) begin
            dvd  <= {dvd[a_width-2:0], q_bit};
            prem <= prem_next;
            cnt  <= cnt - 1'b1;
        end
    end

    // Sign fixup. A zero divisor bypasses the iteration result: all ones
    // unsigned, or the saturated value on the side of the dividend's sign
    // when signed. The most-negative / -1 case needs no special handling:
    // the magnitude quotient is already the wrapped most-negative pattern.
    always_comb begin
        q_fixed = dvd;
        if (div0_r) begin
            if (!tc_r) begin
                q_fixed = '1;
            end else if (a_neg) begin
                q_fixed = {1'b1, {(a_width-1){1'b0}}};
            end else begin
                q_fixed = {1'b0, {(a_width-1){1'b1}}};
            end
        end else if (q_neg) begin
            q_fixed = a_width'(negate(MAX_W'(dvd)));
        end
    end

`ifdef SEQDIV_REM_EN
    // Remainder follows the dividend's sign so that a == q*b + r with
    // truncation toward zero; a zero divisor returns the dividend as-is.
    always_comb begin
        r_fixed = prem[b_width-1:0];
        if (div0_r) begin
            r_fixed = b_width'(a_r);
        end else if (a_neg) begin
            r_fixed = b_width'(negate(MAX_W'(prem[b_width-1:0])));
        end
    end
`endif

    // Result registers are loaded once, in FIXUP, and hold through DONE and
    // any following operation until the next FIXUP or reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quotient_r  <= '0;
            div0_out    <= 1'b0;
`ifdef SEQDIV_REM_EN
            remainder_r <= '0;
`endif
        end else if (state == FIXUP) begin
            quotient_r  <= q_fixed;
            div0_out    <= div0_r;
`ifdef SEQDIV_REM_EN
            remainder_r <= r_fixed;
`endif
        end
    end

    // complete drops on the cycle after a request is taken and rises once
    // DONE has been reached, so it always qualifies settled result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            complete_r <= 1'b0;
        end else if (accept) begin
            complete_r <= 1'b0;
        end else if (state == DONE) begin
            complete_r <= 1'b1;
        end
    end

    assign bus.complete    = complete_r;
    assign bus.divide_by_0 = div0_out;
    assign bus.quotient    = quotient_r;
`ifdef SEQDIV_REM_EN
    assign bus.remainder   = remainder_r;
`else
    assign bus.remainder   = '0;
`endif

endmodule
